otter_mdu_seq: RTL and testbench
================================

# otter_mdu_seq

Multi-cycle unsigned multiply/divide sequencer for the OTTER core. It performs MUL, MULHU, DIVU and REMU by driving the core's shared 32-bit ALU, two ALU operations per bit, over 32 iterations. While BUSY is high the core routes ALU inputs from this block and stalls the pipeline. It returns a single RESULT with a one-cycle DONE pulse.

## Interface
- No parameters; width fixed at 32 bits.
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- START  in  1  request; sampled only in IDLE or DONE state
- OP  in  2  00 MUL (low word), 01 MULHU, 10 DIVU, 11 REMU
- A  in  32  multiplicand / dividend, captured on accepted START
- B  in  32  multiplier / divisor, captured on accepted START
- BUSY  out  1  high while iterating; core muxes ALU inputs from this block and stalls
- DONE  out  1  one-cycle pulse, RESULT valid
- RESULT  out  32  final value, held until the next accepted START
- ALU_A, ALU_B  out  32  operands to the shared ALU
- ALU_FUN  out  4  function to the shared ALU: 0000 ADD, 1000 SUB, 0011 SLTU
- ALU_RESULT  in  32  combinational result from the shared ALU

## Operation
- States: IDLE, ITER_A, ITER_B, DONE.
  - IDLE/DONE + START → ITER_A with iteration count 0.
  - ITER_A → ITER_B.
  - ITER_B → ITER_A, or → DONE after count 31.
  - DONE → IDLE, or → ITER_A if START is high.
- Registers: opa (A), opb (B), hi, lo, tmp, and a 5-bit count.
- Multiply init: hi=0, lo=B.
  - ITER_A: ALU = ADD(hi, opa); tmp = lo[0] ? ALU_RESULT : hi.
  - ITER_B: ALU = SLTU(tmp, opa); c = lo[0] & ALU_RESULT[0].
  - ITER_B update: hi={c,tmp[31:1]}; lo={tmp[0],lo[31:1]}.
- Divide init: hi=0 (remainder), lo=A (quotient/dividend).
  - ITER_A: tmp = {hi[30:0],lo[31]}; msb = hi[31]; ALU = SLTU(tmp, opb) latched as lt.
  - ITER_B: ALU = SUB(tmp, opb); q = msb | ~lt.
  - ITER_B update: hi = q ? ALU_RESULT : tmp; lo = {lo[30:0], q}.
- Final RESULT: MUL=lo, MULHU=hi, DIVU=lo, REMU=hi. All arithmetic is modulo 2^32; carry and borrow come only from SLTU.
- Divisor zero: the algorithm inherently gives DIVU=0xFFFFFFFF and REMU=A (RISC-V semantics). No special case exists without the macro.
- START while BUSY is ignored, and operands are not recaptured.
- Idle outputs: ALU_A=0, ALU_B=0, ALU_FUN=0000.

## Timing
- Reset values: BUSY=0, DONE=0, RESULT=0, ALU_A=0, ALU_B=0, ALU_FUN=0000, state IDLE, count 0.
- START accepted at cycle 0 → BUSY high cycles 1–64 → DONE=1 at cycle 65, with RESULT updated in the same cycle.
- BUSY=0 during the DONE cycle.
- Back-to-back: START in the DONE cycle gives BUSY in the next cycle. Throughput is one operation per 65 cycles.
- ALU path is purely combinational within a cycle (ALU_A/B/FUN → ALU_RESULT → register).
- RST mid-operation: on the next edge, return to IDLE with all outputs at reset values. No DONE is issued for the aborted operation.

## Configuration
- MDU_EARLY_OUT_EN defined: if captured B==0, the block skips the iterations and goes IDLE → DONE.
  - DONE at cycle 1, BUSY never asserted.
  - RESULT: MUL/MULHU 0, DIVU 0xFFFFFFFF, REMU = A.
- MDU_EARLY_OUT_EN undefined: every operation takes the full 65 cycles. Result values are identical.

## Structure
- Package otter_mdu_pkg holds:
  - the op enum (MUL, MULHU, DIVU, REMU)
  - the state enum
  - ALU function constants ALU_ADD=4'b0000, ALU_SUB=4'b1000, ALU_SLTU=4'b0011
  - MDU_ITERS=32
- No sub-module: the ALU stays instantiated in the core and is shared through the ALU_* ports. The block is a single FSM plus datapath.

## Test plan
- MUL A=7, B=6 → DONE at cycle 65, RESULT=42; BUSY high exactly 64 cycles.
- MULHU A=0xFFFFFFFF, B=0xFFFFFFFF → RESULT=0xFFFFFFFE; MUL with the same operands → 0x00000001.
- DIVU 100/7 → 14; REMU 100/7 → 2; then DIVU 0xFFFFFFFF/0x80000001 → 1 and REMU → 0x7FFFFFFE (exercises the msb path).
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DONE at cycle 65 without MDU_EARLY_OUT_EN.
  - DONE at cycle 1 with it.
- START pulsed again at cycles 10 and 40 during a DIVU 100/7 → ignored, RESULT still 14; START in the DONE cycle begins the next operation immediately.
- RST high at cycle 30 of a MUL → BUSY=0, RESULT=0 next cycle, no DONE; a new MUL 3×5 then gives 15 at cycle 65.

Source files
------------

// File: rtl/otter_mdu_pkg.sv
// otter_mdu_pkg
//   Shared types and constants for the OTTER multi-cycle multiply/divide
//   sequencer: operation and state encodings, the function codes it drives
//   onto the core's shared ALU, the iteration count and a result selector.
package otter_mdu_pkg;

  localparam int MDU_ITERS = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ITER_A = 2'b01,
    ST_ITER_B = 2'b10,
    ST_DONE   = 2'b11
  } mdu_state_e;

  // Divide ops share the upper encoding bit.
  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

  // MUL/DIVU return lo, MULHU/REMU return hi; the low op bit picks the half.
  function automatic logic [31:0] select_result(input mdu_op_e op,
                                                input logic [31:0] hi,
                                                input logic [31:0] lo);
    return op[0] ? hi : lo;
  endfunction

endpackage

// File: rtl/otter_mdu_seq.sv
// otter_mdu_seq
//   Multi-cycle unsigned MUL / MULHU / DIVU / REMU sequencer. It borrows the
//   core's 32-bit ALU through the ALU_* ports, two ALU operations per bit
//   over 32 iterations, and returns RESULT with a one-cycle DONE pulse.
//
// Ports
//   CLK, RST          rising-edge clock, synchronous active-high reset
//   START, OP, A, B   request; accepted only in IDLE or DONE state
//   BUSY              high while iterating (core routes ALU from here, stalls)
//   DONE, RESULT      one-cycle completion pulse; RESULT held until next start
//   ALU_A/B/FUN       operands and function driven to the shared ALU
//   ALU_RESULT        combinational result returned by the shared ALU
//
// Configuration
//   MDU_EARLY_OUT_EN  when defined, a request with B==0 skips the iterations
//                     and reports its (identical) result one cycle later.
module otter_mdu_seq
  import otter_mdu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic [31:0] ALU_A,
  output logic [31:0] ALU_B,
  output logic [3:0]  ALU_FUN,
  input  logic [31:0] ALU_RESULT
);

  mdu_state_e  state_q, state_d;
  mdu_op_e     op_q, op_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] tmp_q, tmp_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  count_q, count_d;
  logic        msb_q, msb_d;   // bit shifted out of the remainder (divide)
  logic        lt_q, lt_d;     // shifted remainder < divisor (divide)

  logic        is_div;
  logic [31:0] div_shift;      // remainder shifted left with next dividend bit
  logic        quot_bit;
  logic        carry_bit;

  assign is_div    = op_is_div(op_q);
  assign div_shift = {hi_q[30:0], lo_q[31]};
  assign quot_bit  = msb_q | ~lt_q;
  assign carry_bit = lo_q[0] & ALU_RESULT[0];

  assign BUSY   = (state_q == ST_ITER_A) || (state_q == ST_ITER_B);
  assign DONE   = (state_q == ST_DONE);
  assign RESULT = result_q;

  // ALU drive depends only on registered state so the external ALU path
  // stays a clean feed-forward loop: regs -> ALU_* -> ALU_RESULT -> regs.
  always_comb begin
    ALU_A   = '0;
    ALU_B   = '0;
    ALU_FUN = ALU_ADD;
    unique case (state_q)
      ST_ITER_A: begin
        if (is_div) begin
          ALU_A   = div_shift;
          ALU_B   = opb_q;
          ALU_FUN = ALU_SLTU;
        end else begin
          ALU_A   = hi_q;
          ALU_B   = opa_q;
          ALU_FUN = ALU_ADD;
        end
      end
      ST_ITER_B: begin
        if (is_div) begin
          ALU_A   = tmp_q;
          ALU_B   = opb_q;
          ALU_FUN = ALU_SUB;
        end else begin
          // Sum < addend exactly when the add in ITER_A wrapped.
          ALU_A   = tmp_q;
          ALU_B   = opa_q;
          ALU_FUN = ALU_SLTU;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_d    = tmp_q;
    result_d = result_q;
    count_d  = count_q;
    msb_d    = msb_q;
    lt_d     = lt_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (START) begin
          op_d    = mdu_op_e'(OP);
          opa_d   = A;
          opb_d   = B;
          hi_d    = '0;
          lo_d    = op_is_div(mdu_op_e'(OP)) ? A : B;
          count_d = '0;
          state_d = ST_ITER_A;
`ifdef MDU_EARLY_OUT_EN
          if (B == 32'd0) begin
            // Same values the full iteration would converge to.
            result_d = select_result(mdu_op_e'(OP),
                                     op_is_div(mdu_op_e'(OP)) ? A : 32'd0,
                                     op_is_div(mdu_op_e'(OP)) ? 32'hFFFF_FFFF : 32'd0);
            state_d  = ST_DONE;
          end
`endif
        end
      end

      ST_ITER_A: begin
        if (is_div) begin
          tmp_d = div_shift;
          msb_d = hi_q[31];
          lt_d  = ALU_RESULT[0];
        end else begin
          tmp_d = lo_q[0] ? ALU_RESULT : hi_q;
        end
        state_d = ST_ITER_B;
      end

      ST_ITER_B: begin
        if (is_div) begin
          // A set msb means the shifted remainder is >= 2^32 > divisor.
          hi_d = quot_bit ? ALU_RESULT : tmp_q;
          lo_d = {lo_q[30:0], quot_bit};
        end else begin
          hi_d = {carry_bit, tmp_q[31:1]};
          lo_d = {tmp_q[0], lo_q[31:1]};
        end
        if (count_q == 5'(MDU_ITERS - 1)) begin
          result_d = select_result(op_q, hi_d, lo_d);
          state_d  = ST_DONE;
        end else begin
          count_d = count_q + 5'd1;
          state_d = ST_ITER_A;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      opa_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_q    <= '0;
      result_q <= '0;
      count_q  <= '0;
      msb_q    <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_q    <= tmp_d;
      result_q <= result_d;
      count_q  <= count_d;
      msb_q    <= msb_d;
      lt_q     <= lt_d;
    end
  end

endmodule

// File: tb/tb_otter_mdu_seq.sv
// tb_otter_mdu_seq
//   Directed bench for otter_mdu_seq with a behavioural model of the core's
//   shared ALU (ADD, SUB, SLTU). Expected results are hand-computed constants.
//   Honours MDU_EARLY_OUT_EN for the divide-by-zero latency expectations.
`timescale 1ns/1ps
module tb_otter_mdu_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [1:0]  OP = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;
  logic [31:0] ALU_A;
  logic [31:0] ALU_B;
  logic [3:0]  ALU_FUN;
  logic [31:0] ALU_RESULT;

  int n_checks = 0;
  int n_errors = 0;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 CLK = ~CLK;

  // Shared ALU as it sits in the core.
  always_comb begin
    ALU_RESULT = '0;
    case (ALU_FUN)
      4'b0000: ALU_RESULT = ALU_A + ALU_B;
      4'b1000: ALU_RESULT = ALU_A - ALU_B;
      4'b0011: ALU_RESULT = {31'd0, (ALU_A < ALU_B)};
      default: ALU_RESULT = '0;
    endcase
  end

  otter_mdu_seq dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .OP         (OP),
    .A          (A),
    .B          (B),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .RESULT     (RESULT),
    .ALU_A      (ALU_A),
    .ALU_B      (ALU_B),
    .ALU_FUN    (ALU_FUN),
    .ALU_RESULT (ALU_RESULT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one request (we are at posedge+1) and follow it to DONE.
  // pulse: re-assert START with different operands at cycles 10 and 40.
  task automatic do_op(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit early, input bit pulse);
    int cyc;
    int busy_cnt;
    START = 1'b1; OP = op; A = a; B = b;
    step();
    START = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    if (!early) check({tag, " busy_c1"}, 32'(BUSY), 32'd1);
    while (!DONE && cyc < 200) begin
      if (BUSY) busy_cnt++;
      if (pulse && (cyc == 10 || cyc == 40)) begin
        START = 1'b1; OP = 2'b00; A = 32'h0000_1234; B = 32'h0000_0003;
      end else begin
        START = 1'b0; OP = op; A = a; B = b;
      end
      step();
      cyc++;
    end
    START = 1'b0;
    check({tag, " done_cycle"}, 32'(cyc), early ? 32'd1 : 32'd65);
    check({tag, " busy_cycles"}, 32'(busy_cnt), early ? 32'd0 : 32'd64);
    check({tag, " busy_in_done"}, 32'(BUSY), 32'd0);
    check({tag, " result"}, RESULT, exp);
    $display("txn %-14s op=%0d a=0x%08h b=0x%08h result=0x%08h done_cycle=%0d",
             tag, op, a, b, RESULT, cyc);
  endtask

  initial begin
    int seen_done;

    RST = 1'b1;
    step();
    step();
    check("rst busy", 32'(BUSY), 32'd0);
    check("rst done", 32'(DONE), 32'd0);
    check("rst result", RESULT, 32'd0);
    check("rst alu_a", ALU_A, 32'd0);
    check("rst alu_b", ALU_B, 32'd0);
    check("rst alu_fun", 32'(ALU_FUN), 32'd0);
    RST = 1'b0;
    step();

    do_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0);
    step();
    check("done_pulse", 32'(DONE), 32'd0);
    check("result_held", RESULT, 32'd42);
    check("idle alu_fun", 32'(ALU_FUN), 32'd0);

    do_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    // Back-to-back: next request issued in the DONE cycle.
    do_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    do_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
    do_op("divu_msb", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 1'b0, 1'b0);
    do_op("remu_msb", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0, 1'b0);
    do_op("divu_5_0", 2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, EARLY, 1'b0);
    do_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, EARLY, 1'b0);
    do_op("mulhu_x_0", 2'b01, 32'h1234_5678, 32'd0, 32'd0, EARLY, 1'b0);
    do_op("divu_ignore", 2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
    step();

    // Reset in the middle of a multiply.
    START = 1'b1; OP = 2'b00; A = 32'd9; B = 32'd9;
    step();
    START = 1'b0;
    for (int c = 1; c < 30; c++) step();
    RST = 1'b1;
    step();
    check("midrst busy", 32'(BUSY), 32'd0);
    check("midrst done", 32'(DONE), 32'd0);
    check("midrst result", RESULT, 32'd0);
    check("midrst alu_fun", 32'(ALU_FUN), 32'd0);
    RST = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 70; c++) begin
      step();
      if (DONE) seen_done++;
    end
    check("midrst no_done", 32'(seen_done), 32'd0);
    $display("txn %-14s aborted at cycle 30", "mul_rst");

    do_op("mul_3x5", 2'b00, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
